// File: rtl/shift_rate_controller.sv
// ============================================================================
// Module   : shift_rate_controller
// Function : Turns next/faster/slower buttons into a display mode and speed
//            level, and issues rate-controlled one-cycle shift enables.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_rate_controller #(
    parameter int BASE_PERIOD = 8,
    parameter int CNT_WIDTH   = 10,
    parameter int WIDTH       = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       next,
    input  logic       faster,
    input  logic       slower,
    input  logic       pause,
    output logic       shift_left,
    output logic       shift_right,
    output logic [2:0] level,
    output logic [1:0] mode
);

    typedef enum logic [1:0] {
        S_LEFT   = 2'b00,
        S_RIGHT  = 2'b01,
        S_BOUNCE = 2'b10,
        S_HOLD   = 2'b11
    } mode_t;

    localparam logic [CNT_WIDTH-1:0] c_base      = CNT_WIDTH'(BASE_PERIOD);
    localparam logic [CNT_WIDTH-1:0] c_one       = CNT_WIDTH'(1);
    localparam logic [2:0]           c_level_max = 3'd4;
    localparam logic [2:0]           c_level_rst = 3'd2;
    localparam int                   c_bw        = (WIDTH > 2) ? $clog2(WIDTH - 1) : 1;
    localparam logic [c_bw-1:0]      c_bounce_last = c_bw'(WIDTH - 2);

    // Previous-value registers reset high so a button held through reset
    // does not register as a press on release.
    logic r_next_prev;
    logic r_faster_prev;
    logic r_slower_prev;

    logic                 r_dir;
    logic [2:0]           r_level;
    mode_t                r_mode;
    logic [CNT_WIDTH-1:0] r_count;
    logic [c_bw-1:0]      r_bounce_cnt;
    logic                 r_shift_left;
    logic                 r_shift_right;

    logic                 w_next_edge;
    logic                 w_faster_edge;
    logic                 w_slower_edge;
    logic [2:0]           w_level_nxt;
    logic                 w_level_chg;
    mode_t                w_mode_nxt;
    logic [CNT_WIDTH-1:0] w_period_m1;
    logic                 w_wrap;
    logic                 w_tick;
    logic [CNT_WIDTH-1:0] w_count_nxt;
    logic [c_bw-1:0]      w_bounce_nxt;
    logic                 w_dir_nxt;
    logic                 w_shift_left_nxt;
    logic                 w_shift_right_nxt;

    assign w_next_edge   = next   & ~r_next_prev;
    assign w_faster_edge = faster & ~r_faster_prev;
    assign w_slower_edge = slower & ~r_slower_prev;

    // Speed level: saturating, simultaneous presses cancel out.
    always_comb begin
        w_level_nxt = r_level;
        if (w_faster_edge && !w_slower_edge && (r_level != c_level_max)) begin
            w_level_nxt = r_level + 3'd1;
        end else if (w_slower_edge && !w_faster_edge && (r_level != 3'd0)) begin
            w_level_nxt = r_level - 3'd1;
        end
    end

    assign w_level_chg = (w_level_nxt != r_level);

    always_comb begin
        w_period_m1 = c_base - c_one;
        case (r_level)
            3'd0:    w_period_m1 = (c_base << 4) - c_one;
            3'd1:    w_period_m1 = (c_base << 3) - c_one;
            3'd2:    w_period_m1 = (c_base << 2) - c_one;
            3'd3:    w_period_m1 = (c_base << 1) - c_one;
            default: w_period_m1 = c_base - c_one;
        endcase
    end

    // A restart (level or mode change) takes precedence over a coinciding wrap.
    assign w_wrap = !pause && (r_count == w_period_m1);
    assign w_tick = w_wrap && !w_level_chg && !w_next_edge;

    always_comb begin
        w_count_nxt = r_count;
        if (w_level_chg || w_next_edge) begin
            w_count_nxt = '0;
        end else if (!pause) begin
            w_count_nxt = w_wrap ? '0 : (r_count + c_one);
        end
    end

    // Mode FSM next-state and pulse generation.
    always_comb begin
        w_mode_nxt        = r_mode;
        w_bounce_nxt      = r_bounce_cnt;
        w_dir_nxt         = r_dir;
        w_shift_left_nxt  = 1'b0;
        w_shift_right_nxt = 1'b0;

        if (w_next_edge) begin
            case (r_mode)
                S_LEFT:   w_mode_nxt = S_RIGHT;
                S_RIGHT:  w_mode_nxt = S_BOUNCE;
                S_BOUNCE: w_mode_nxt = S_HOLD;
                default:  w_mode_nxt = S_LEFT;
            endcase
            w_bounce_nxt = '0;
            w_dir_nxt    = 1'b0;
        end else if (w_tick) begin
            case (r_mode)
                S_LEFT:  w_shift_left_nxt  = 1'b1;
                S_RIGHT: w_shift_right_nxt = 1'b1;
                S_BOUNCE: begin
                    w_shift_left_nxt  = !r_dir;
                    w_shift_right_nxt = r_dir;
                    if (r_bounce_cnt == c_bounce_last) begin
                        w_bounce_nxt = '0;
                        w_dir_nxt    = !r_dir;
                    end else begin
                        w_bounce_nxt = r_bounce_cnt + c_bw'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_next_prev   <= 1'b1;
            r_faster_prev <= 1'b1;
            r_slower_prev <= 1'b1;
            r_level       <= c_level_rst;
            r_mode        <= S_LEFT;
            r_count       <= '0;
            r_bounce_cnt  <= '0;
            r_dir         <= 1'b0;
            r_shift_left  <= 1'b0;
            r_shift_right <= 1'b0;
        end else begin
            r_next_prev   <= next;
            r_faster_prev <= faster;
            r_slower_prev <= slower;
            r_level       <= w_level_nxt;
            r_mode        <= w_mode_nxt;
            r_count       <= w_count_nxt;
            r_bounce_cnt  <= w_bounce_nxt;
            r_dir         <= w_dir_nxt;
            r_shift_left  <= w_shift_left_nxt;
            r_shift_right <= w_shift_right_nxt;
        end
    end

    assign shift_left  = r_shift_left;
    assign shift_right = r_shift_right;
    assign level       = r_level;
    assign mode        = r_mode;

endmodule

`default_nettype wire
